// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data memory between
// the CPU load/store port and the debug/loader port, with in-order read return.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic [DATA_W/8-1:0] dbg_be,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    input  logic                dbg_lock,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // Handshake: a requester raises req with stable we/addr/wdata/be and holds
    // them until the cycle its gnt is high; that cycle is the transfer. Dropping
    // req before gnt withdraws the request. Read data returns RD_LAT cycles later
    // as a one-cycle rvalid pulse, in grant order.

    logic              last_dbg;
    logic              cpu_win;
    logic              dbg_win;
    logic              rd_push;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_own;
    logic              ret_v;
    logic              ret_own;
    logic              cpu_pend;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_hold;

    // Grants are gated by rst_n so nothing reaches the memory while in reset.
    always_comb begin
        cpu_win = rst_n & cpu_req & ~dbg_lock & (~dbg_req | last_dbg);
        dbg_win = rst_n & dbg_req & ~cpu_win;
    end

    assign cpu_gnt   = cpu_win;
    assign dbg_gnt   = dbg_win;
    assign mem_en    = cpu_win | dbg_win;
    assign mem_we    = cpu_win ? cpu_we    : (dbg_win & dbg_we);
    assign mem_addr  = cpu_win ? cpu_addr  : dbg_addr;
    assign mem_wdata = cpu_win ? cpu_wdata : dbg_wdata;
    assign mem_be    = cpu_win ? cpu_be    : dbg_be;
    assign rd_push   = mem_en & ~mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg <= 1'b1;
        end else if (mem_en) begin
            last_dbg <= dbg_win;
        end
    end

    // Owner pipeline: bit set means the read in that slot belongs to dbg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            pipe_own <= '0;
        end else begin
            pipe_v[0]   <= rd_push;
            pipe_own[0] <= dbg_win;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign ret_v      = pipe_v[RD_LAT-1];
    assign ret_own    = pipe_own[RD_LAT-1];
    assign cpu_rvalid = ret_v & ~ret_own;
    assign dbg_rvalid = ret_v & ret_own;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= mem_rdata;
            if (dbg_rvalid) dbg_hold <= mem_rdata;
        end
    end

    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold;

    // A CPU read still in flight keeps the CPU stalled, except in its return slot.
    always_comb begin
        cpu_pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            cpu_pend = cpu_pend | (pipe_v[i] & ~pipe_own[i]);
        end
    end

    assign cpu_stall = (cpu_req & ~cpu_win) | (cpu_win & ~cpu_we) | cpu_pend;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RD_LAT=1 and RD_LAT=2 instances driven in lockstep,
// checked against a transaction-level model of arbitration and read return.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [9:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic [3:0]  cpu_be, dbg_be;

    logic [1:0]       o_cgnt, o_dgnt, o_cstall, o_crv, o_drv, o_men, o_mwe;
    logic [1:0][9:0]  o_maddr;
    logic [1:0][31:0] o_mwd, o_crd, o_drd, o_mrd;
    logic [1:0][3:0]  o_mbe;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [1024];
        logic [31:0] rd_p [2];

        dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(g + 1)) dut (
            .clk(clk), .rst_n(rst_n),
            .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
            .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
            .cpu_gnt(o_cgnt[g]), .cpu_stall(o_cstall[g]),
            .cpu_rvalid(o_crv[g]), .cpu_rdata(o_crd[g]),
            .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
            .dbg_wdata(dbg_wdata), .dbg_be(dbg_be),
            .dbg_gnt(o_dgnt[g]), .dbg_rvalid(o_drv[g]), .dbg_rdata(o_drd[g]),
            .dbg_lock(dbg_lock),
            .mem_en(o_men[g]), .mem_we(o_mwe[g]), .mem_addr(o_maddr[g]),
            .mem_wdata(o_mwd[g]), .mem_be(o_mbe[g]), .mem_rdata(o_mrd[g])
        );

        // memory with a synchronous read and an optional extra output register
        always @(posedge clk) begin
            if (o_men[g] && o_mwe[g]) begin
                for (int b = 0; b < 4; b++)
                    if (o_mbe[g][b]) mem[o_maddr[g]][b*8 +: 8] <= o_mwd[g][b*8 +: 8];
            end
            if (o_men[g] && !o_mwe[g]) rd_p[0] <= mem[o_maddr[g]];
            rd_p[1] <= rd_p[0];
        end
        assign o_mrd[g] = rd_p[g];
    end

    // reference model
    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          gcyc;
    } rd_t;

    rd_t         exp_q[$];
    int          hd [2];
    logic [31:0] ref_mem [1024];
    logic [31:0] last_rd [2][2];
    logic        last_dbg_m;
    int          cyc;
    int          checks;
    int          failures;
    logic        eg_c, eg_d;
    logic        tbl_on, tbl_c, tbl_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hd[0] = 0;
        hd[1] = 0;
        last_dbg_m = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) last_rd[d][p] = '0;
    endtask

    task automatic step();
        logic ec, ed;
        if (!rst_n) begin
            ec = 0; ed = 0;
        end else if (dbg_lock) begin
            ec = 0; ed = dbg_req;
        end else if (cpu_req && dbg_req) begin
            ec = last_dbg_m; ed = !last_dbg_m;
        end else begin
            ec = cpu_req; ed = dbg_req;
        end
        eg_c = ec;
        eg_d = ed;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic rv_c, rv_d, pend;
            logic [31:0] rdat;
            string s;
            s = $sformatf("[lat%0d]", d + 1);
            rv_c = 0; rv_d = 0; rdat = '0; pend = 0;
            if (hd[d] < exp_q.size() && exp_q[hd[d]].gcyc + d + 1 == cyc) begin
                rdat = exp_q[hd[d]].data;
                if (exp_q[hd[d]].owner) rv_d = 1; else rv_c = 1;
            end
            for (int i = hd[d]; i < exp_q.size(); i++)
                if (!exp_q[i].owner && exp_q[i].gcyc + d + 1 > cyc) pend = 1;
            chk({"cpu_gnt", s}, 32'(o_cgnt[d]), 32'(ec));
            chk({"dbg_gnt", s}, 32'(o_dgnt[d]), 32'(ed));
            chk({"mem_en", s}, 32'(o_men[d]), 32'(ec | ed));
            chk({"mem_we", s}, 32'(o_mwe[d]), 32'((ec && cpu_we) || (ed && dbg_we)));
            if (ec || ed) begin
                chk({"mem_addr", s}, 32'(o_maddr[d]), 32'(ec ? cpu_addr : dbg_addr));
                chk({"mem_wdata", s}, o_mwd[d], ec ? cpu_wdata : dbg_wdata);
                chk({"mem_be", s}, 32'(o_mbe[d]), 32'(ec ? cpu_be : dbg_be));
            end
            chk({"cpu_stall", s}, 32'(o_cstall[d]),
                32'((cpu_req && !ec) || (ec && !cpu_we) || pend));
            chk({"cpu_rvalid", s}, 32'(o_crv[d]), 32'(rv_c));
            chk({"dbg_rvalid", s}, 32'(o_drv[d]), 32'(rv_d));
            chk({"cpu_rdata", s}, o_crd[d], rv_c ? rdat : last_rd[d][0]);
            chk({"dbg_rdata", s}, o_drd[d], rv_d ? rdat : last_rd[d][1]);
            if (tbl_on) begin
                chk({"tbl_cpu_gnt", s}, 32'(o_cgnt[d]), 32'(tbl_c));
                chk({"tbl_dbg_gnt", s}, 32'(o_dgnt[d]), 32'(tbl_d));
            end
            if (rv_c) last_rd[d][0] = rdat;
            if (rv_d) last_rd[d][1] = rdat;
            if (rv_c || rv_d) hd[d]++;
        end
        @(posedge clk);
        if (rst_n && (ec || ed)) begin
            logic        we;
            logic [9:0]  a;
            logic [31:0] wd;
            logic [3:0]  be;
            we = ec ? cpu_we : dbg_we;
            a  = ec ? cpu_addr : dbg_addr;
            wd = ec ? cpu_wdata : dbg_wdata;
            be = ec ? cpu_be : dbg_be;
            last_dbg_m = ed;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                exp_q.push_back('{owner: ed, data: ref_mem[a], gcyc: cyc});
            end
        end
        cyc++;
        #1;
    endtask

    // driver tasks
    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
        dbg_lock = 0;
    endtask

    task automatic gen_cpu();
        cpu_req   = ($urandom_range(0, 9) < 6);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 10'($urandom_range(0, 15));
        cpu_wdata = $urandom;
        cpu_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic gen_dbg();
        dbg_req   = ($urandom_range(0, 9) < 6);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 10'($urandom_range(0, 15));
        dbg_wdata = $urandom;
        dbg_be    = 4'($urandom_range(0, 15));
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [9:0]  caddr;
        logic [31:0] cwd;
        logic [3:0]  cbe;
        logic        dreq, dwe;
        logic [9:0]  daddr;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        lock, ecg, edg;
    } vec_t;

    function automatic vec_t mk(
        input logic creq, input logic cwe, input logic [9:0] ca, input logic [31:0] cd,
        input logic [3:0] cb, input logic dreq, input logic dwe, input logic [9:0] da,
        input logic [31:0] dd, input logic [3:0] db, input logic lk,
        input logic ecg, input logic edg);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cwd = cd; v.cbe = cb;
        v.dreq = dreq; v.dwe = dwe; v.daddr = da; v.dwd = dd; v.dbe = db;
        v.lock = lk; v.ecg = ecg; v.edg = edg;
        return v;
    endfunction

    vec_t vt [21];

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        tbl_on = 0; tbl_c = 0; tbl_d = 0;
        idle_inputs();
        model_reset();
        rst_n = 0;

        vt[0]  = mk(0,0,10'h000,32'h0,4'h0, 0,0,10'h000,32'h0,4'h0, 0, 0,0);
        vt[1]  = mk(1,1,10'h009,32'h7,4'hF, 1,1,10'h100,32'hAAAA5555,4'hF, 0, 1,0);
        vt[2]  = mk(0,0,10'h000,32'h0,4'h0, 1,1,10'h100,32'hAAAA5555,4'hF, 0, 0,1);
        vt[3]  = mk(1,0,10'h009,32'h0,4'hF, 0,0,10'h000,32'h0,4'h0, 0, 1,0);
        vt[4]  = mk(0,0,10'h000,32'h0,4'h0, 0,0,10'h000,32'h0,4'h0, 0, 0,0);
        vt[5]  = mk(0,0,10'h000,32'h0,4'h0, 0,0,10'h000,32'h0,4'h0, 0, 0,0);
        vt[6]  = mk(0,0,10'h000,32'h0,4'h0, 1,0,10'h100,32'h0,4'hF, 0, 0,1);
        for (int i = 7; i <= 12; i++)
            vt[i] = mk(1,0,10'h009,32'h0,4'hF, 1,0,10'h100,32'h0,4'hF, 0,
                       (i % 2 == 1), (i % 2 == 0));
        for (int i = 13; i <= 16; i++)
            vt[i] = mk(1,0,10'h009,32'h0,4'hF, 1,0,10'h100,32'h0,4'hF, 1, 0,1);
        vt[17] = mk(1,0,10'h009,32'h0,4'hF, 1,0,10'h100,32'h0,4'hF, 0, 1,0);
        vt[18] = mk(0,0,10'h000,32'h0,4'h0, 1,0,10'h100,32'h0,4'hF, 1, 0,1);
        vt[19] = mk(0,0,10'h000,32'h0,4'h0, 0,0,10'h000,32'h0,4'h0, 0, 0,0);
        vt[20] = mk(0,0,10'h000,32'h0,4'h0, 0,0,10'h000,32'h0,4'h0, 0, 0,0);

        // reset with requests pending: nothing may be granted
        cpu_req = 1; dbg_req = 1;
        step();
        idle_inputs();
        step();
        rst_n = 1;

        // directed table
        tbl_on = 1;
        for (int i = 0; i < 21; i++) begin
            cpu_req = vt[i].creq; cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr;
            cpu_wdata = vt[i].cwd; cpu_be = vt[i].cbe;
            dbg_req = vt[i].dreq; dbg_we = vt[i].dwe; dbg_addr = vt[i].daddr;
            dbg_wdata = vt[i].dwd; dbg_be = vt[i].dbe;
            dbg_lock = vt[i].lock;
            tbl_c = vt[i].ecg; tbl_d = vt[i].edg;
            step();
        end
        tbl_on = 0;

        // reset the cycle after a dbg read grant: that read must never return
        idle_inputs();
        dbg_req = 1; dbg_addr = 10'h100; dbg_be = 4'hF;
        step();
        idle_inputs();
        rst_n = 0;
        model_reset();
        step();
        step();
        rst_n = 1;
        cpu_req = 1; cpu_addr = 10'h009; cpu_be = 4'hF;
        dbg_req = 1; dbg_addr = 10'h100; dbg_be = 4'hF;
        tbl_on = 1; tbl_c = 1; tbl_d = 0;
        step();
        tbl_on = 0;
        idle_inputs();
        step();
        step();

        // preload the random-test address window
        for (int a = 0; a < 16; a++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = 10'(a); dbg_wdata = $urandom; dbg_be = 4'hF;
            step();
        end
        idle_inputs();

        // randomized traffic, requesters hold until granted or withdraw
        gen_cpu();
        gen_dbg();
        for (int n = 0; n < 400; n++) begin
            dbg_lock = ($urandom_range(0, 5) == 0);
            step();
            if (eg_c || !cpu_req) gen_cpu();
            else if ($urandom_range(0, 7) == 0) cpu_req = 0;
            if (eg_d || !dbg_req) gen_dbg();
            else if ($urandom_range(0, 7) == 0) dbg_req = 0;
        end
        idle_inputs();
        for (int n = 0; n < 4; n++) step();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
